// File: rtl/fetch_unit.sv
// 8080 instruction fetch stage: issues byte reads to a fixed 2-cycle memory port,
// queues returned bytes and assembles 1-3 byte instructions for decode.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] raddr,
    input  logic [15:0] rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [15:0] ins_pc,
    output logic [7:0]  ins_opcode,
    output logic [15:0] ins_operand,
    output logic [1:0]  ins_len
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);

    function automatic logic [1:0] op_len(input logic [7:0] op);
        logic [1:0] len;
        len = 2'd1;
        casez (op)
            8'b00??0001, 8'h22, 8'h2A, 8'h32, 8'h3A, 8'hC3, 8'hCB,
            8'b11???010, 8'hCD, 8'hDD, 8'hED, 8'hFD, 8'b11???100: len = 2'd3;
            8'b00???110, 8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE,
            8'hF6, 8'hFE, 8'hD3, 8'hDB:                           len = 2'd2;
            default:                                              len = 2'd1;
        endcase
        return len;
    endfunction

    logic [15:0]          fetch_pc_q, fetch_pc_d;
    logic [15:0]          dec_pc_q, dec_pc_d;
    logic                 epoch_q, epoch_d;
    logic                 s0_v_q, s0_v_d, s0_e_q, s0_e_d;
    logic                 s1_v_q, s1_v_d, s1_e_q, s1_e_d;
    logic [QDEPTH*8-1:0]  q_q, q_d;
    logic [CW-1:0]        q_cnt_q, q_cnt_d;
    logic                 ins_valid_q, ins_valid_d;
    logic [15:0]          ins_pc_q, ins_pc_d;
    logic [7:0]           ins_opcode_q, ins_opcode_d;
    logic [15:0]          ins_operand_q, ins_operand_d;
    logic [1:0]           ins_len_q, ins_len_d;

    logic [1:0]           head_len;
    logic [CW:0]          occ;
    logic                 issue, push, slot_free, assemble;
    logic [CW-1:0]        pop_n, wr_idx;
    logic                 rdata_unused;

    assign rdata_unused = ^rdata[15:8];

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        dec_pc_d      = dec_pc_q;
        epoch_d       = epoch_q;
        q_d           = q_q;
        q_cnt_d       = q_cnt_q;
        ins_valid_d   = ins_valid_q;
        ins_pc_d      = ins_pc_q;
        ins_opcode_d  = ins_opcode_q;
        ins_operand_d = ins_operand_q;
        ins_len_d     = ins_len_q;

        head_len  = op_len(q_q[7:0]);
        // Credit: queued bytes plus both pipe stages must stay below QDEPTH.
        occ       = {1'b0, q_cnt_q} + (CW + 1)'(s0_v_q) + (CW + 1)'(s1_v_q);
        issue     = !redirect && (occ < (CW + 1)'(QDEPTH));
        push      = s1_v_q && (s1_e_q == epoch_q);
        slot_free = !ins_valid_q || ins_ready;
        assemble  = !redirect && slot_free && (q_cnt_q >= CW'(head_len));
        pop_n     = assemble ? CW'(head_len) : '0;
        wr_idx    = q_cnt_q - pop_n;

        if (issue) begin
            fetch_pc_d = fetch_pc_q + 16'd1;
        end
        s0_v_d = issue;
        s0_e_d = epoch_q;
        s1_v_d = s0_v_q;
        s1_e_d = s0_e_q;

        q_d = q_q >> (8 * pop_n);
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            if (push && (wr_idx == CW'(i))) begin
                q_d[i*8 +: 8] = rdata[7:0];
            end
        end
        q_cnt_d = wr_idx + CW'(push);

        if (slot_free) begin
            ins_valid_d = 1'b0;
        end
        if (assemble) begin
            ins_valid_d   = 1'b1;
            ins_pc_d      = dec_pc_q;
            ins_opcode_d  = q_q[7:0];
            ins_len_d     = head_len;
            ins_operand_d = (head_len == 2'd3) ? q_q[23:8]
                          : (head_len == 2'd2) ? {8'h00, q_q[15:8]} : 16'h0000;
            dec_pc_d      = dec_pc_q + {14'd0, head_len};
        end

        // A transfer in the redirect cycle still completes; the flush only clears state.
        if (redirect) begin
            fetch_pc_d  = redirect_pc;
            dec_pc_d    = redirect_pc;
            q_cnt_d     = '0;
            ins_valid_d = 1'b0;
            epoch_d     = ~epoch_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            dec_pc_q      <= RESET_PC;
            epoch_q       <= 1'b0;
            s0_v_q        <= 1'b0;
            s0_e_q        <= 1'b0;
            s1_v_q        <= 1'b0;
            s1_e_q        <= 1'b0;
            q_q           <= '0;
            q_cnt_q       <= '0;
            ins_valid_q   <= 1'b0;
            ins_pc_q      <= '0;
            ins_opcode_q  <= '0;
            ins_operand_q <= '0;
            ins_len_q     <= 2'd1;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            dec_pc_q      <= dec_pc_d;
            epoch_q       <= epoch_d;
            s0_v_q        <= s0_v_d;
            s0_e_q        <= s0_e_d;
            s1_v_q        <= s1_v_d;
            s1_e_q        <= s1_e_d;
            q_q           <= q_d;
            q_cnt_q       <= q_cnt_d;
            ins_valid_q   <= ins_valid_d;
            ins_pc_q      <= ins_pc_d;
            ins_opcode_q  <= ins_opcode_d;
            ins_operand_q <= ins_operand_d;
            ins_len_q     <= ins_len_d;
        end
    end

    assign raddr       = fetch_pc_q;
    assign ins_valid   = ins_valid_q;
    assign ins_pc      = ins_pc_q;
    assign ins_opcode  = ins_opcode_q;
    assign ins_operand = ins_operand_q;
    assign ins_len     = ins_len_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 2-cycle-latency memory model and a transfer log.
module tb_fetch_unit;

    localparam int unsigned QDEPTH = 4;

    typedef struct packed {
        logic [15:0] pc;
        logic [7:0]  op;
        logic [15:0] opnd;
        logic [1:0]  len;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] raddr;
    logic [15:0] rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        ins_valid;
    logic        ins_ready;
    logic [15:0] ins_pc;
    logic [7:0]  ins_opcode;
    logic [15:0] ins_operand;
    logic [1:0]  ins_len;

    logic [7:0]  mem [0:65535];
    logic [7:0]  rd1;
    xfer_t       xq[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    fetch_unit #(.RESET_PC(16'h0000), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_pc(ins_pc),
        .ins_opcode(ins_opcode), .ins_operand(ins_operand), .ins_len(ins_len)
    );

    always #5 clk = ~clk;

    // Address in cycle k -> byte on rdata during cycle k+2; upper byte is junk.
    always @(posedge clk) begin
        rd1   <= mem[raddr];
        rdata <= {8'hA5, rd1};
    end

    always @(negedge clk) begin
        if (rst_n && ins_valid && ins_ready)
            xq.push_back('{ins_pc, ins_opcode, ins_operand, ins_len});
        if (rst_n) begin
            n_checks++;
            if (dut.q_cnt_q > 3'(QDEPTH)) begin
                n_fail++;
                $display("FAIL queue_overflow: got %0d expected <= %0d", dut.q_cnt_q, QDEPTH);
            end
        end
    end

    function automatic xfer_t mk(logic [15:0] pc, logic [7:0] op, logic [15:0] opnd, logic [1:0] len);
        return '{pc, op, opnd, len};
    endfunction

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_prog(bit with_target);
        foreach (mem[i]) mem[i] = 8'h00;
        mem[16'h0001] = 8'h3E; mem[16'h0002] = 8'h55;
        mem[16'h0003] = 8'hC3; mem[16'h0004] = 8'h34; mem[16'h0005] = 8'h12;
        if (with_target) begin
            mem[16'h0100] = 8'h3A; mem[16'h0101] = 8'h00; mem[16'h0102] = 8'h20;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; ins_ready = 1'b0;
        step(2);
        rst_n = 1'b1;
        xq.delete();
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!ins_valid && cycles < 40) begin
            step(1);
            cycles++;
        end
        n_checks++;
        if (!ins_valid) begin
            n_fail++;
            $display("FAIL wait_valid: got ins_valid=0 expected 1 within 40 cycles");
        end
    endtask

    task automatic test_reset();
        load_prog(1'b0);
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; ins_ready = 1'b1;
        step(2);
        n_checks++;
        if ({raddr, ins_valid, ins_pc, ins_opcode, ins_operand, ins_len} !== {16'h0000, 1'b0, 16'h0, 8'h0, 16'h0, 2'd1}) begin
            n_fail++;
            $display("FAIL reset_state: got raddr=%h v=%b pc=%h op=%h opnd=%h len=%0d expected 0000 0 0000 00 0000 1",
                     raddr, ins_valid, ins_pc, ins_opcode, ins_operand, ins_len);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        xfer_t exp [3];
        int    cyc;
        exp[0] = mk(16'h0000, 8'h00, 16'h0000, 2'd1);
        exp[1] = mk(16'h0001, 8'h3E, 16'h0055, 2'd2);
        exp[2] = mk(16'h0003, 8'hC3, 16'h1234, 2'd3);
        load_prog(1'b0);
        do_reset();
        ins_ready = 1'b1;
        wait_valid(cyc);
        n_checks++;
        if (cyc < 3) begin
            n_fail++;
            $display("FAIL first_valid_latency: got %0d cycles expected >= 3", cyc);
        end
        step(10);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= xq.size() || xq[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL basic_xfer%0d: got %h expected %h", i, (i < xq.size()) ? xq[i] : '0, exp[i]);
            end
        end
    endtask

    task automatic test_stall();
        xfer_t exp [4];
        xfer_t snap;
        int    cyc;
        exp[0] = mk(16'h0000, 8'h00, 16'h0000, 2'd1);
        exp[1] = mk(16'h0001, 8'h3E, 16'h0055, 2'd2);
        exp[2] = mk(16'h0003, 8'hC3, 16'h1234, 2'd3);
        exp[3] = mk(16'h0006, 8'h00, 16'h0000, 2'd1);
        load_prog(1'b0);
        do_reset();
        wait_valid(cyc);
        snap = '{ins_pc, ins_opcode, ins_operand, ins_len};
        for (int i = 0; i < 10; i++) begin
            step(1);
            n_checks++;
            if ({ins_valid, ins_pc, ins_opcode, ins_operand, ins_len} !== {1'b1, snap}) begin
                n_fail++;
                $display("FAIL stall_stable%0d: got v=%b %h expected v=1 %h", i, ins_valid,
                         {ins_pc, ins_opcode, ins_operand, ins_len}, snap);
            end
        end
        n_checks++;
        if (raddr !== 16'h0005) begin
            n_fail++;
            $display("FAIL stall_raddr: got %h expected 0005", raddr);
        end
        ins_ready = 1'b1;
        step(12);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= xq.size() || xq[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL stall_xfer%0d: got %h expected %h", i, (i < xq.size()) ? xq[i] : '0, exp[i]);
            end
        end
    endtask

    task automatic test_redirect();
        xfer_t exp [2];
        exp[0] = mk(16'h0100, 8'h3A, 16'h2000, 2'd3);
        exp[1] = mk(16'h0103, 8'h00, 16'h0000, 2'd1);
        foreach (mem[i]) mem[i] = 8'h00;
        mem[16'h0100] = 8'h3A; mem[16'h0101] = 8'h00; mem[16'h0102] = 8'h20;
        do_reset();
        ins_ready = 1'b1;
        step(5);
        redirect = 1'b1; redirect_pc = 16'h0100;
        step(1);
        redirect = 1'b0;
        n_checks++;
        if ({raddr, ins_valid} !== {16'h0100, 1'b0}) begin
            n_fail++;
            $display("FAIL redirect_flush: got raddr=%h v=%b expected 0100 0", raddr, ins_valid);
        end
        xq.delete();
        step(12);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (i >= xq.size() || xq[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL redirect_xfer%0d: got %h expected %h", i, (i < xq.size()) ? xq[i] : '0, exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        xfer_t exp [2];
        exp[0] = mk(16'hFFFE, 8'hCD, 16'h8000, 2'd3);
        exp[1] = mk(16'h0001, 8'h00, 16'h0000, 2'd1);
        foreach (mem[i]) mem[i] = 8'h00;
        mem[16'hFFFE] = 8'hCD; mem[16'hFFFF] = 8'h00; mem[16'h0000] = 8'h80;
        do_reset();
        ins_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        step(1);
        redirect = 1'b0;
        xq.delete();
        step(12);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (i >= xq.size() || xq[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL wrap_xfer%0d: got %h expected %h", i, (i < xq.size()) ? xq[i] : '0, exp[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        xfer_t exp [2];
        int    cyc;
        exp[0] = mk(16'h0000, 8'h00, 16'h0000, 2'd1);
        exp[1] = mk(16'h0001, 8'h3E, 16'h0055, 2'd2);
        load_prog(1'b0);
        do_reset();
        wait_valid(cyc);
        step(2);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ins_valid, raddr} !== {1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b raddr=%h expected 0 0000", ins_valid, raddr);
        end
        step(1);
        rst_n = 1'b1;
        ins_ready = 1'b1;
        xq.delete();
        step(10);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (i >= xq.size() || xq[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL async_restart%0d: got %h expected %h", i, (i < xq.size()) ? xq[i] : '0, exp[i]);
            end
        end
    endtask

    task automatic test_redirect_transfer();
        xfer_t exp [2];
        int    cyc;
        int    hits;
        exp[0] = mk(16'h0000, 8'h00, 16'h0000, 2'd1);
        exp[1] = mk(16'h0100, 8'h3A, 16'h2000, 2'd3);
        load_prog(1'b1);
        do_reset();
        ins_ready = 1'b1;
        wait_valid(cyc);
        redirect = 1'b1; redirect_pc = 16'h0100;
        step(1);
        redirect = 1'b0;
        step(12);
        hits = 0;
        foreach (xq[i]) if (xq[i].pc == 16'h0000) hits++;
        n_checks++;
        if (hits != 1) begin
            n_fail++;
            $display("FAIL redir_xfer_count: got %0d expected 1", hits);
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (i >= xq.size() || xq[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL redir_xfer%0d: got %h expected %h", i, (i < xq.size()) ? xq[i] : '0, exp[i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; ins_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_wrap();
        test_async_reset();
        test_redirect_transfer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the 8080 memory's read port 0.
- Drives the read address and collects the returned opcode/operand bytes in a small byte queue.
- Assembles complete 1–3 byte 8080 instructions and hands them to decode over a valid/ready handshake.
- Handles control-flow redirects by flushing in-flight reads and the queue.

Parameters:
- RESET_PC, 16'h0000, fetch address after reset.
- QDEPTH, 4, byte queue entries; must be ≥3, covering the longest instruction.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- raddr  out  16  byte address to memory read port 0.
- rdata  in  16  memory read data; only [7:0] used, [15:8] ignored.
- redirect  in  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  in  16  new fetch address, valid with redirect.
- ins_valid  out  1  assembled instruction available.
- ins_ready  in  1  decode accepts the instruction this cycle.
- ins_pc  out  16  address of the opcode byte.
- ins_opcode  out  8  first byte.
- ins_operand  out  16  {byte3,byte2}; unused bytes are 0; 2-byte instruction gives {8'h00,byte2}.
- ins_len  out  2  1, 2 or 3.

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC; raddr=RESET_PC.
  - Queue empty, in-flight pipe empty, epoch=0.
  - ins_valid=0; ins_pc/opcode/operand=0; ins_len=1.
- Memory latency is fixed at 2:
  - An address on raddr during cycle k returns its byte on rdata[7:0] during cycle k+2.
  - Fetch captures that byte at the end of cycle k+2.
  - In-flight tracking is a 2-stage shift of {valid, epoch}.
- Issue: raddr = fetch_pc every cycle. A read counts as issued when queue_count + inflight_count + (byte returning this cycle) < QDEPTH.
  - On issue, fetch_pc increments by 1, wrapping FFFF→0000.
  - When not issuing, raddr holds and nothing enters the pipe.
- Return: a byte whose tag epoch equals the current epoch is pushed to the queue. A mismatched byte is discarded.
  - Credit accounting guarantees the queue never overflows; an overflow is a bench assertion failure.
- Length decode of queue head opcode:
  - Length 3: 00xx0001 (LXI), 22, 2A, 32, 3A, C3, CB, 11ccc010 (Jcc), CD, DD, ED, FD, 11ccc100 (Ccc).
  - Length 2: 00rrr110 (MVI), C6, CE, D6, DE, E6, EE, F6, FE, D3, DB.
  - Length 1: all others.
- Assembly: when queue_count ≥ len and the output slot is free (ins_valid=0, or ins_ready=1 this cycle):
  - Pop len bytes and load the output register next cycle.
  - ins_pc tracks the decode PC; it advances by len per assembled instruction, mod 2^16.
- Handshake:
  - Output fields are stable while ins_valid=1 and ins_ready=0.
  - Transfer occurs on ins_valid & ins_ready.
  - Back-to-back transfers at 1 instruction/cycle are allowed when bytes are available.
- Redirect (highest priority):
  - Next cycle: fetch_pc=redirect_pc, decode PC=redirect_pc, queue cleared, ins_valid=0, epoch toggled.
  - An issue attempt in the redirect cycle is suppressed; raddr shows redirect_pc from the next cycle.
  - Bytes returning in the redirect cycle and the following two cycles carry the old epoch and are dropped.
- Redirect while ins_valid & ins_ready in the same cycle: the transfer completes and the instruction is consumed, then the flush applies.
- Back-to-back redirects: the last one wins; each toggles epoch. Stale bytes are still dropped because the pipe is only 2 deep.
- Reset mid-operation clears everything immediately; in-flight reads are forgotten.

Test Plan:
- Reset, memory 0000:00(NOP),3E 55(MVI A),C3 34 12(JMP), ins_ready=1 → instructions {pc0000,00,len1,0000}, {0001,3E,len2,0055}, {0003,C3,len3,1234}; first ins_valid no earlier than cycle 3 after reset release.
- Hold ins_ready=0 for 10 cycles after first ins_valid → outputs stable; raddr stops advancing once queue+inflight=QDEPTH; release → no bytes lost or duplicated.
- Redirect to 0100 (holding 3A 00 20) while two reads are in flight → stale bytes dropped; next instruction {0100,3A,len3,2000}.
- Fetch starting at FFFE with bytes CD,00 and 0000=80 → CALL 8000 assembled across the wrap; ins_pc=FFFE; next pc 0001.
- Assert rst_n=0 asynchronously mid-instruction with ins_valid=1 → ins_valid drops without a clock edge; after release fetch restarts at RESET_PC.
- Redirect in the same cycle as a valid&ready transfer → that instruction counted once; next instruction comes from redirect_pc.
